// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like memory interface.
//   SIZE_*    : encodings of data_size (2'b11 is treated as a word access)
//   state_t   : responder FSM state encoding
//   byte_mask : byte-lane enable for a (size, addr[1:0]) pair; also used by d_cache
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_A = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Halfwords pick their lanes from addr[1] only, so an odd halfword
    // address silently lands on the enclosing aligned half.
    function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: byte_mask = 4'b0001 << addr_lo;
            SIZE_HALF: byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   byte_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length).
//   clk, rst : clock, synchronous active-high reset (loads seed)
//   en       : advance one step this cycle
//   seed     : non-zero reset value
//   q        : current register contents
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/sram_like_mem_slave.sv
// Responder end of the sram-like cache/memory interface: a single-port word
// memory that accepts one request at a time and answers with a one-cycle
// data_ok pulse a fixed number of cycles after acceptance.
//   clk, rst      : clock, synchronous active-high reset (memory is not cleared)
//   data_req      : request valid, held by the master until data_addr_ok
//   data_wr       : 1 = write, 0 = read
//   data_size     : 00 byte, 01 half, 10/11 word
//   data_addr     : byte address; word index is addr[ADDR_WIDTH+1:2]
//   data_wdata    : write data, lanes aligned to the address
//   data_rdata    : full read word, meaningful only while data_data_ok
//   data_addr_ok  : request accepted this cycle (combinational)
//   data_data_ok  : one-cycle completion pulse
module sram_like_mem_slave
    import sram_like_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          ADDR_LAT   = 0,
    parameter int          DATA_LAT   = 2,
    parameter int          STALL_EN   = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = 16;

    // The IDLE cycle in which req first appears already counts as one held
    // cycle, so WAIT_A starts one short of ADDR_LAT.
    localparam logic [CNT_W-1:0] A_LOAD = (ADDR_LAT > 0) ? CNT_W'(ADDR_LAT - 1) : '0;
    // The acceptance cycle and the RESP cycle bracket the BUSY countdown, so
    // BUSY lasts DATA_LAT-1 cycles (DATA_LAT=1 skips BUSY entirely).
    localparam logic [CNT_W-1:0] B_LOAD = (DATA_LAT > 1) ? CNT_W'(DATA_LAT - 2) : '0;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [3:0]              lat_mask;
    logic                    lat_wr;
    logic [31:0]             lat_wdata;
    logic [31:0]             mem [0:DEPTH-1];

    logic [15:0]             lfsr_q;
    logic                    stall;
    logic                    accept;
    logic                    enter_resp;
    logic [ADDR_WIDTH-1:0]   resp_idx;
    logic                    resp_wr;
    logic                    unused_bits;

    if (STALL_EN != 0) begin : g_lfsr
        lfsr16 u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .en   (1'b1),
            .seed (LFSR_SEED),
            .q    (lfsr_q)
        );
    end else begin : g_no_lfsr
        assign lfsr_q = LFSR_SEED;
    end

    assign stall = (STALL_EN != 0) && lfsr_q[0];

    // Upper address bits alias by design; the LFSR only contributes bit 0.
    assign unused_bits = ^{data_addr[31:ADDR_WIDTH+2], lfsr_q[15:1]};

    always_comb begin
        accept = 1'b0;
        if (!rst && data_req) begin
            case (state)
                ST_IDLE:   accept = (ADDR_LAT == 0) && !stall;
                ST_WAIT_A: accept = (cnt == '0);
                default:   accept = 1'b0;
            endcase
        end
    end

    assign data_addr_ok = accept;

    // With DATA_LAT=1 the response follows acceptance directly, so the
    // read index has to come from the live bus rather than the latches.
    always_comb begin
        enter_resp = ((state == ST_BUSY) && (cnt == '0)) || (accept && (DATA_LAT <= 1));
        resp_idx   = (state == ST_BUSY) ? lat_idx : data_addr[ADDR_WIDTH+1:2];
        resp_wr    = (state == ST_BUSY) ? lat_wr  : data_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            data_data_ok <= 1'b0;
            data_rdata   <= '0;
        end else begin
            data_data_ok <= enter_resp;
            data_rdata   <= (enter_resp && !resp_wr) ? mem[resp_idx] : '0;

            if (accept) begin
                lat_idx   <= data_addr[ADDR_WIDTH+1:2];
                lat_mask  <= byte_mask(data_size, data_addr[1:0]);
                lat_wr    <= data_wr;
                lat_wdata <= data_wdata;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= (DATA_LAT <= 1) ? ST_RESP : ST_BUSY;
                        cnt   <= B_LOAD;
                    end else if (data_req) begin
                        state <= ST_WAIT_A;
                        cnt   <= A_LOAD;
                    end
                end
                ST_WAIT_A: begin
                    if (!data_req) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (accept) begin
                        state <= (DATA_LAT <= 1) ? ST_RESP : ST_BUSY;
                        cnt   <= B_LOAD;
                    end else if (!stall) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Writes commit on the edge that ends RESP; a reset in that cycle drops them.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_RESP) && lat_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_mask[b]) begin
                    mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Scoreboard bench for sram_like_mem_slave: three instances (defaults,
// ADDR_LAT=3, STALL_EN=1) driven by one stimulus process; a monitor process
// pops expected responses whenever an instance raises data_ok.
module tb_sram_like_mem_slave;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  addr_ok;
    logic [2:0]  data_ok;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mdl [3][1024];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    bit          busy    [3];
    int          acc_cyc [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_like_mem_slave #(
            .ADDR_WIDTH (10),
            .ADDR_LAT   ((g == 1) ? 3 : 0),
            .DATA_LAT   (2),
            .STALL_EN   ((g == 2) ? 1 : 0),
            .LFSR_SEED  (16'hACE1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .data_req     (req[g]),
            .data_wr      (wr[g]),
            .data_size    (size[g]),
            .data_addr    (addr[g]),
            .data_wdata   (wdata[g]),
            .data_rdata   (rdata[g]),
            .data_addr_ok (addr_ok[g]),
            .data_data_ok (data_ok[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void qpush(input int g, input logic [31:0] v);
        case (g)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic logic [31:0] qpop(input int g);
        case (g)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qsize(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Reference memory: byte-granular update from the size/address rules.
    function automatic void mdl_write(input int g, input logic [1:0] sz,
                                      input logic [31:0] a, input logic [31:0] d);
        int idx;
        int first;
        int nb;
        idx = int'((a >> 2) & 32'h3FF);
        if (sz == 2'd0) begin
            nb = 1; first = int'(a % 4);
        end else if (sz == 2'd1) begin
            nb = 2; first = ((a % 4) >= 2) ? 2 : 0;
        end else begin
            nb = 4; first = 0;
        end
        for (int b = first; b < first + nb; b++) begin
            mdl[g][idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] mdl_read(input int g, input logic [31:0] a);
        return mdl[g][int'((a >> 2) & 32'h3FF)];
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic do_req(input int g, input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, output int ncyc);
        bit acc;
        req[g] = 1'b1; wr[g] = w; size[g] = sz; addr[g] = a; wdata[g] = d;
        acc  = 1'b0;
        ncyc = 0;
        while (!acc && ncyc < 64) begin
            @(negedge clk);
            ncyc++;
            if (addr_ok[g]) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        req[g] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst%0d: no addr_ok in %0d cycles, required within 64", g, ncyc);
        end else if (w) begin
            mdl_write(g, sz, a, d);
            qpush(g, 32'h0);
        end else begin
            qpush(g, mdl_read(g, a));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: overlap, latency and data checks on every addr_ok/data_ok.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (rst[g]) begin
                    busy[g] = 1'b0;
                end else begin
                    if (addr_ok[g]) begin
                        chk($sformatf("no_overlap_inst%0d", g), 32'(busy[g]), 32'd0);
                        busy[g]    = 1'b1;
                        acc_cyc[g] = cyc;
                    end
                    if (data_ok[g]) begin
                        if (qsize(g) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_data_ok inst%0d: data_ok=1 with nothing outstanding, required 0", g);
                        end else begin
                            e = qpop(g);
                            chk($sformatf("rdata_inst%0d", g), rdata[g], e);
                            chk($sformatf("latency_inst%0d", g), 32'(cyc - acc_cyc[g]), 32'd2);
                        end
                        busy[g] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int g = 0; g < 3; g++) begin
            size[g] = 2'd0; addr[g] = '0; wdata[g] = '0; busy[g] = 1'b0; acc_cyc[g] = 0;
        end
        wr  = '0;
        req = 3'b001;
        rst = 3'b111;

        // Reset held 3 cycles, with a request pending on instance 0.
        @(posedge clk);
        #1;
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("rst_addr_ok_inst%0d", g), 32'(addr_ok[g]), 32'd0);
                chk($sformatf("rst_data_ok_inst%0d", g), 32'(data_ok[g]), 32'd0);
                chk($sformatf("rst_rdata_inst%0d", g), rdata[g], 32'd0);
            end
            @(posedge clk);
            #1;
        end
        rst = 3'b000;
        req = 3'b000;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("post_rst_addr_ok_inst%0d", g), 32'(addr_ok[g]), 32'd0);
            chk($sformatf("post_rst_data_ok_inst%0d", g), 32'(data_ok[g]), 32'd0);
            chk($sformatf("post_rst_rdata_inst%0d", g), rdata[g], 32'd0);
        end
        @(posedge clk);
        #1;

        // Word write/read and sub-word merges on the default instance.
        do_req(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, n);
        chk("lat0_same_cycle_accept", 32'(n), 32'd1);
        do_req(0, 1'b0, 2'd2, 32'h10, 32'h0, n);
        do_req(0, 1'b1, 2'd0, 32'h13, 32'h5A00_0000, n);
        do_req(0, 1'b0, 2'd2, 32'h10, 32'h0, n);
        do_req(0, 1'b1, 2'd1, 32'h10, 32'h0000_1234, n);
        do_req(0, 1'b0, 2'd2, 32'h10, 32'h0, n);
        // Aliasing, then write-back immediately followed by refill.
        do_req(0, 1'b1, 2'd2, 32'h1010, 32'hCAFEF00D, n);
        do_req(0, 1'b0, 2'd2, 32'h0010, 32'h0, n);
        do_req(0, 1'b1, 2'd2, 32'h1020, 32'hA5A5A5A5, n);
        do_req(0, 1'b0, 2'd2, 32'h0020, 32'h0, n);
        idle(4);

        // Reset while the write is in BUSY: must not complete or commit.
        req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'd2; addr[0] = 32'h20; wdata[0] = 32'h11111111;
        @(negedge clk);
        chk("abort_accept", 32'(addr_ok[0]), 32'd1);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_data_ok_in_rst", 32'(data_ok[0]), 32'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_data_ok", 32'(data_ok[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        do_req(0, 1'b0, 2'd2, 32'h20, 32'h0, n);
        idle(4);

        // ADDR_LAT=3: held request accepted in its 4th cycle; dropped one is ignored.
        do_req(1, 1'b1, 2'd2, 32'h40, 32'h01020304, n);
        chk("addr_lat3_accept_cycle", 32'(n), 32'd4);
        idle(4);
        req[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'd2; addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("drop_addr_ok_first", 32'(addr_ok[1]), 32'd0);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("drop_addr_ok", 32'(addr_ok[1]), 32'd0);
            chk("drop_data_ok", 32'(data_ok[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        do_req(1, 1'b0, 2'd2, 32'h40, 32'h0, n);

        // Randomized traffic over 16 words with aliased upper address bits.
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 16; i++) begin
                do_req(g, 1'b1, 2'd2, 32'(i * 4), $urandom, n);
            end
            for (int i = 0; i < ((g == 2) ? 200 : 50); i++) begin
                w  = 1'($urandom % 2);
                sz = 2'($urandom % 4);
                a  = ($urandom & 32'hFFFF_F000) | ($urandom % 64);
                do_req(g, w, sz, a, $urandom, n);
            end
        end

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
